// File: rtl/int_pe_stream.sv
// rtl/int_pe_stream.sv - weight-stationary integer dot-product engine with streamed activations
module int_pe_stream #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int NCH   = 4,
    parameter int DEPTH = 64,
    parameter int ACCW  = 27
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(DEPTH):0]    cfg_len,
    input  logic                      cfg_signed,
    input  logic                      cfg_reuse,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [NCH*LANES*DW-1:0]   w_data,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic [LANES*DW-1:0]       x_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCH*ACCW-1:0]       out_data,
    output logic [NCH-1:0]            out_ovf,
    output logic                      busy
);
    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW  = LANES * DW;
    localparam int WW  = NCH * XW;
    localparam int PRW = 2 * DW + 2;
    localparam int SW  = PRW + $clog2(LANES);
    localparam int AW  = ((SW > ACCW) ? SW : ACCW) + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          len_q, wptr_q, rptr_q;
    logic                   signed_q, wts_loaded_q;
    logic                   v1_q, v2_q;
    logic                   cfg_take, w_fire, x_fire, run_entry;
    logic [WW-1:0]          mem [DEPTH];
    logic [WW-1:0]          w1_q;
    logic [XW-1:0]          x1_q;
    logic signed [SW-1:0]   sum_d [NCH];
    logic signed [SW-1:0]   sum_q [NCH];
    logic [NCH*ACCW-1:0]    acc_q, acc_d;
    logic [NCH-1:0]         ovf_q, ovf_d;
    logic signed [AW-1:0]   tot;

    function automatic logic signed [PRW-1:0] ext(input logic [DW-1:0] v, input logic s);
        return {{(PRW-DW){s & v[DW-1]}}, v};
    endfunction

    // Heap-ordered binary tree: leaves at LANES-1.., node i sums children 2i+1 and 2i+2.
    function automatic logic signed [SW-1:0] chan_sum(input logic [XW-1:0] wv,
                                                      input logic [XW-1:0] xv,
                                                      input logic s);
        logic signed [SW-1:0]  node [2*LANES-1];
        logic signed [PRW-1:0] pa, pb, pr;
        for (int i = 0; i < LANES; i++) begin
            pa = ext(wv[i*DW +: DW], s);
            pb = ext(xv[i*DW +: DW], s);
            pr = pa * pb;
            node[LANES-1+i] = {{(SW-PRW){pr[PRW-1]}}, pr};
        end
        for (int i = LANES - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        return node[0];
    endfunction

    always_comb begin
        state_d   = state_q;
        w_ready   = 1'b0;
        x_ready   = 1'b0;
        out_valid = 1'b0;
        cfg_take  = 1'b0;
        w_fire    = 1'b0;
        x_fire    = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start && (cfg_len != '0) && (cfg_len <= DEPTH_L)) begin
                    cfg_take = 1'b1;
                    state_d  = (cfg_reuse && wts_loaded_q) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                w_fire  = w_valid;
                if (w_valid && (wptr_q == len_q - LW'(1))) state_d = S_RUN;
            end
            S_RUN: begin
                x_ready = 1'b1;
                x_fire  = x_valid;
                if (x_valid && (rptr_q == len_q - LW'(1))) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!v1_q && !v2_q) state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign run_entry = (state_d == S_RUN) && (state_q != S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            signed_q     <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            wts_loaded_q <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_take) begin
                len_q    <= cfg_len;
                signed_q <= cfg_signed;
            end
            if (w_fire) begin
                if (state_d == S_RUN) begin
                    wptr_q       <= '0;
                    wts_loaded_q <= 1'b1;
                end else begin
                    wptr_q <= wptr_q + LW'(1);
                end
            end
            if (run_entry) rptr_q <= '0;
            else if (x_fire) rptr_q <= rptr_q + LW'(1);
            v1_q <= x_fire;
            v2_q <= v1_q;
        end
    end

    // Buffer and pipeline data are unreset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_fire) mem[wptr_q[PW-1:0]] <= w_data;
        if (x_fire) begin
            x1_q <= x_data;
            w1_q <= mem[rptr_q[PW-1:0]];
        end
        if (v1_q) begin
            for (int c = 0; c < NCH; c++) sum_q[c] <= sum_d[c];
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            sum_d[c] = chan_sum(w1_q[c*XW +: XW], x1_q, signed_q);
        end
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        tot   = '0;
        if (v2_q) begin
            for (int c = 0; c < NCH; c++) begin
                tot = {{(AW-ACCW){acc_q[c*ACCW+ACCW-1]}}, acc_q[c*ACCW +: ACCW]}
                    + {{(AW-SW){sum_q[c][SW-1]}}, sum_q[c]};
                if (tot > SAT_MAX) begin
                    tot      = SAT_MAX;
                    ovf_d[c] = 1'b1;
                end else if (tot < SAT_MIN) begin
                    tot      = SAT_MIN;
                    ovf_d[c] = 1'b1;
                end
                acc_d[c*ACCW +: ACCW] = tot[ACCW-1:0];
            end
        end
    end

    // The accumulators double as the result registers; they persist until the next RUN entry.
    always_ff @(posedge clk) begin
        if (reset || run_entry) begin
            acc_q <= '0;
            ovf_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_data = acc_q;
    assign out_ovf  = ovf_q;
endmodule

// File: tb/tb_int_pe_stream.sv
// tb/tb_int_pe_stream.sv - scoreboard bench for int_pe_stream (default and ACCW=18 builds)
module tb_int_pe_stream;
    localparam int AA = 27;
    localparam int AB = 18;
    localparam int WW = 4 * 16 * 8;
    localparam int XW = 16 * 8;

    typedef struct packed {
        logic [3:0]       ovf;
        logic [3:0][31:0] v;
    } exp_t;

    logic clk, reset, start, cfg_signed, cfg_reuse, w_valid, x_valid, out_ready;
    logic [6:0] cfg_len;
    logic [WW-1:0] w_data;
    logic [XW-1:0] x_data;
    logic w_ready_a, x_ready_a, out_valid_a, busy_a;
    logic w_ready_b, x_ready_b, out_valid_b, busy_b;
    logic [4*AA-1:0] out_data_a;
    logic [4*AB-1:0] out_data_b;
    logic [3:0] out_ovf_a, out_ovf_b;

    int errors = 0;
    int checks = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic [WW-1:0] wword;
    logic [XW-1:0] xword;

    int_pe_stream dut_a (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
        .cfg_reuse(cfg_reuse), .w_valid(w_valid), .w_ready(w_ready_a), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready_a), .x_data(x_data), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a), .busy(busy_a)
    );

    int_pe_stream #(.ACCW(AB)) dut_b (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
        .cfg_reuse(cfg_reuse), .w_valid(w_valid), .w_ready(w_ready_b), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready_b), .x_data(x_data), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_ovf(out_ovf_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input int v0, input int v1, input int v2, input int v3,
                                input logic [3:0] o);
        exp_t e;
        e.ovf  = o;
        e.v[0] = v0;
        e.v[1] = v1;
        e.v[2] = v2;
        e.v[3] = v3;
        return e;
    endfunction

    function automatic logic [WW-1:0] wfill(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        logic [WW-1:0] r;
        logic [7:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 16; i++) r[(c*16+i)*8 +: 8] = b[c];
        return r;
    endfunction

    function automatic logic [XW-1:0] xseq(input int base, input int step);
        logic [XW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(base + step * i);
        return r;
    endfunction

    always begin
        @(negedge clk);
        #1;
        if (!reset && out_valid_a && out_ready) begin
            chk("a_sb_nonempty", longint'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                for (int c = 0; c < 4; c++)
                    chk($sformatf("a_ch%0d", c), longint'($signed(out_data_a[c*AA +: AA])),
                        longint'($signed(ea.v[c])));
                chk("a_ovf", longint'(out_ovf_a), longint'(ea.ovf));
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (!reset && out_valid_b && out_ready) begin
            chk("b_sb_nonempty", longint'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                eb = q_b.pop_front();
                for (int c = 0; c < 4; c++)
                    chk($sformatf("b_ch%0d", c), longint'($signed(out_data_b[c*AB +: AB])),
                        longint'($signed(eb.v[c])));
                chk("b_ovf", longint'(out_ovf_b), longint'(eb.ovf));
            end
        end
    end

    task automatic do_start(input int len, input bit sgn, input bit reuse);
        start = 1'b1; cfg_len = 7'(len); cfg_signed = sgn; cfg_reuse = reuse;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_load(input int len);
        int n = 0;
        int t = 0;
        w_valid = 1'b1; w_data = wword;
        while (n < len && t < 2000) begin
            if (w_ready_a) n++;
            @(negedge clk);
            t++;
        end
        w_valid = 1'b0;
        chk("load_count", longint'(n), longint'(len));
    endtask

    task automatic do_run(input int len, input bit rnd, input bit hold);
        int n = 0;
        int t = 0;
        bit stable = 1'b1;
        logic [4*AA-1:0] cap_a;
        logic [4*AB-1:0] cap_b;
        if (hold) out_ready = 1'b0;
        while (n < len && t < 4000) begin
            x_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            x_data  = xword;
            if (x_valid && x_ready_a) n++;
            @(negedge clk);
            t++;
        end
        x_valid = 1'b0;
        chk("run_count", longint'(n), longint'(len));
        repeat (2) @(negedge clk);
        chk("lat_not_early", longint'(out_valid_a), 0);
        @(negedge clk);
        chk("lat_k_plus_4", longint'(out_valid_a), 1);
        if (hold) begin
            cap_a = out_data_a;
            cap_b = out_data_b;
            for (int i = 0; i < 10; i++) begin
                if (i == 4) begin start = 1'b1; cfg_len = 7'd1; cfg_reuse = 1'b0; end
                if (i == 5) start = 1'b0;
                @(negedge clk);
                if (out_data_a !== cap_a || out_data_b !== cap_b || !out_valid_a) stable = 1'b0;
            end
            chk("hold_stable", longint'(stable), 1);
            out_ready = 1'b1;
        end
        t = 0;
        while (busy_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("pass_idle", longint'(busy_a), 0);
        chk("idle_no_wready", longint'(w_ready_a), 0);
    endtask

    task automatic pass(input int len, input bit sgn, input bit reuse, input bit rnd,
                        input bit hold);
        do_start(len, sgn, reuse);
        if (!reuse) begin
            do_load(len);
        end else begin
            chk("reuse_no_wready", longint'(w_ready_a), 0);
            chk("reuse_in_run", longint'(x_ready_a), 1);
        end
        do_run(len, rnd, hold);
    endtask

    initial begin
        bit quiet;
        reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_signed = 1'b0; cfg_reuse = 1'b0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", longint'(busy_a | busy_b), 0);
        chk("rst_out_valid", longint'(out_valid_a | out_valid_b), 0);
        chk("rst_out_data", longint'((out_data_a != '0) || (out_data_b != '0)), 0);
        chk("rst_out_ovf", longint'(out_ovf_a | out_ovf_b), 0);
        chk("rst_ready", longint'(w_ready_a | x_ready_a), 0);

        // unsigned identity: weights 1, x lanes 0..15
        wword = wfill(8'h01, 8'h01, 8'h01, 8'h01);
        xword = xseq(0, 1);
        q_a.push_back(mk(120, 120, 120, 120, 4'h0));
        q_b.push_back(mk(120, 120, 120, 120, 4'h0));
        pass(1, 1'b0, 1'b0, 1'b0, 1'b0);

        // signed and unsigned extremes, second pass reuses the buffer
        wword = wfill(8'h80, 8'h80, 8'h80, 8'h80);
        xword = xseq(-128, 0);
        q_a.push_back(mk(16777216, 16777216, 16777216, 16777216, 4'h0));
        q_b.push_back(mk(131071, 131071, 131071, 131071, 4'hF));
        pass(64, 1'b1, 1'b0, 1'b0, 1'b0);
        q_a.push_back(mk(16777216, 16777216, 16777216, 16777216, 4'h0));
        q_b.push_back(mk(131071, 131071, 131071, 131071, 4'hF));
        pass(64, 1'b0, 1'b1, 1'b0, 1'b0);

        // saturation then a reuse pass with zero activations
        wword = wfill(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        xword = xseq(127, 0);
        q_a.push_back(mk(4129024, 4129024, 4129024, 4129024, 4'h0));
        q_b.push_back(mk(131071, 131071, 131071, 131071, 4'hF));
        pass(16, 1'b1, 1'b0, 1'b0, 1'b0);
        xword = '0;
        q_a.push_back(mk(0, 0, 0, 0, 4'h0));
        q_b.push_back(mk(0, 0, 0, 0, 4'h0));
        pass(16, 1'b1, 1'b1, 1'b0, 1'b0);

        // mixed signs: channel weight c-2, lane activation i-8; gap-free then stressed
        wword = wfill(8'hFE, 8'hFF, 8'h00, 8'h01);
        xword = xseq(-8, 1);
        q_a.push_back(mk(128, 64, 0, -64, 4'h0));
        q_b.push_back(mk(128, 64, 0, -64, 4'h0));
        pass(8, 1'b1, 1'b0, 1'b0, 1'b0);
        q_a.push_back(mk(128, 64, 0, -64, 4'h0));
        q_b.push_back(mk(128, 64, 0, -64, 4'h0));
        pass(8, 1'b1, 1'b1, 1'b1, 1'b1);

        // reset during a reuse pass clears outputs and the loaded flag
        do_start(4, 1'b1, 1'b1);
        chk("rr_in_run", longint'(x_ready_a), 1);
        xword = xseq(1, 0);
        x_valid = 1'b1; x_data = xword;
        repeat (2) @(negedge clk);
        x_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_acc_nonzero", longint'(out_data_a != '0), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rr_busy", longint'(busy_a | busy_b), 0);
        chk("rr_ready", longint'(w_ready_a | x_ready_a | out_valid_a), 0);
        chk("rr_data", longint'((out_data_a != '0) || (out_data_b != '0)), 0);
        chk("rr_ovf", longint'(out_ovf_a | out_ovf_b), 0);
        do_start(4, 1'b0, 1'b1);
        chk("rr_reload", longint'(w_ready_a), 1);
        wword = wfill(8'h01, 8'h01, 8'h01, 8'h01);
        q_a.push_back(mk(64, 64, 64, 64, 4'h0));
        q_b.push_back(mk(64, 64, 64, 64, 4'h0));
        do_load(4);
        do_run(4, 1'b0, 1'b0);

        // illegal lengths are ignored
        for (int k = 0; k < 2; k++) begin
            do_start((k == 0) ? 0 : 65, 1'b0, 1'b0);
            quiet = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (busy_a || w_ready_a || x_ready_a) quiet = 1'b0;
                @(negedge clk);
            end
            chk((k == 0) ? "reject_len0" : "reject_len65", longint'(quiet), 1);
        end

        repeat (3) @(negedge clk);
        chk("sb_a_drained", longint'(q_a.size()), 0);
        chk("sb_b_drained", longint'(q_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
